// File: rtl/sd_pkg.sv
// Shared types and helpers for the srdy/drdy packer blocks.
package sd_pkg;

    typedef enum logic {FILL, PEND} sd_pack_state_t;

    function automatic int sd_lane_cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/sd_packer_acc.sv
// Lane accumulator for sd_packer: collects beats into lanes, tracks the lane index and
// holds a finished word in PEND while the output register is still occupied.
module sd_packer_acc
    import sd_pkg::*;
#(
    parameter int iwidth = 8,
    parameter int ratio  = 4,
    parameter int cntsz  = sd_lane_cnt_w(ratio)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_vld,
    input  logic [iwidth-1:0]       i_data,
    input  logic                    i_eop,
    input  logic                    i_out_free,
    output logic                    o_fill,
    output logic                    o_k_last,
    output logic                    o_complete,
    output logic [iwidth*ratio-1:0] o_word,
    output logic [cntsz-1:0]        o_cnt,
    output logic                    o_eop
);

    localparam int KW = (ratio > 1) ? $clog2(ratio) : 1;

    sd_pack_state_t          r_state;
    sd_pack_state_t          w_state_nxt;
    logic [KW-1:0]           r_k;
    logic [iwidth*ratio-1:0] r_acc;
    logic [iwidth*ratio-1:0] w_lane;
    logic                    r_eop;
    logic [cntsz-1:0]        r_cnt;
    logic                    w_completing;
    logic [cntsz-1:0]        w_k_cnt;

    assign o_fill       = (r_state == FILL);
    assign o_k_last     = (r_k == KW'(ratio - 1));
    assign w_completing = i_eop | o_k_last;
    assign w_k_cnt      = cntsz'(r_k) + cntsz'(1);

    // Accumulator with the incoming beat merged into lane k.
    always_comb begin
        w_lane = r_acc;
        for (int j = 0; j < ratio; j++) begin
            if (r_k == KW'(j)) w_lane[j*iwidth +: iwidth] = i_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_complete  = 1'b0;
        o_word      = r_acc;
        o_cnt       = r_cnt;
        o_eop       = r_eop;
        case (r_state)
            FILL: begin
                o_word = w_lane;
                o_cnt  = w_k_cnt;
                o_eop  = i_eop;
                if (i_vld && w_completing) begin
                    if (i_out_free) o_complete  = 1'b1;
                    else            w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (i_out_free) begin
                    o_complete  = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= FILL;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_k   <= '0;
            r_eop <= 1'b0;
            r_cnt <= '0;
        end else if (o_complete) begin
            r_acc <= '0;
            r_k   <= '0;
        end else if (o_fill && i_vld) begin
            r_acc <= w_lane;
            if (w_completing) begin
                r_eop <= i_eop;
                r_cnt <= w_k_cnt;
            end else begin
                r_k <= r_k + KW'(1);
            end
        end
    end

endmodule

// File: rtl/sd_packer.sv
// Narrow-to-wide srdy/drdy gearbox: packs ratio beats per word, eop flushes a partial word.
// Holds the registered output stage and the input handshake around sd_packer_acc.
module sd_packer
    import sd_pkg::*;
#(
    parameter int iwidth = 8,
    parameter int ratio  = 4,
    parameter int cntsz  = sd_lane_cnt_w(ratio)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    c_srdy,
    output logic                    c_drdy,
    input  logic [iwidth-1:0]       c_data,
    input  logic                    c_eop,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [iwidth*ratio-1:0] p_data,
    output logic                    p_eop,
    output logic [cntsz-1:0]        p_cnt
);

    logic                    w_out_free;
    logic                    w_acc_vld;
    logic                    w_fill;
    logic                    w_k_last;
    logic                    w_complete;
    logic [iwidth*ratio-1:0] w_word;
    logic [cntsz-1:0]        w_cnt;
    logic                    w_eop;

    assign w_out_free = ~p_srdy | p_drdy;
    // Only the last lane needs room downstream; earlier lanes just fill the accumulator.
    assign c_drdy     = w_fill & (~w_k_last | w_out_free);
    assign w_acc_vld  = c_srdy & c_drdy;

    sd_packer_acc #(
        .iwidth (iwidth),
        .ratio  (ratio),
        .cntsz  (cntsz)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .i_vld      (w_acc_vld),
        .i_data     (c_data),
        .i_eop      (c_eop),
        .i_out_free (w_out_free),
        .o_fill     (w_fill),
        .o_k_last   (w_k_last),
        .o_complete (w_complete),
        .o_word     (w_word),
        .o_cnt      (w_cnt),
        .o_eop      (w_eop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            p_srdy <= 1'b0;
            p_data <= '0;
            p_eop  <= 1'b0;
            p_cnt  <= '0;
        end else if (w_complete) begin
            p_srdy <= 1'b1;
            p_data <= w_word;
            p_eop  <= w_eop;
            p_cnt  <= w_cnt;
        end else if (p_drdy) begin
            p_srdy <= 1'b0;
        end
    end

endmodule
